// File: rtl/pong_game_ctrl_pkg.sv
// Shared types and constants for the Pong design: FSM state encoding,
// score type, play-field resolution and the speed-ramp helper.
package pong_pkg;

  localparam int unsigned X_RES = 800;
  localparam int unsigned Y_RES = 600;

  typedef logic [3:0] score_t;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SERVE_WAIT = 3'd1,
    ST_PLAY       = 3'd2,
    ST_PAUSED     = 3'd3,
    ST_POINT      = 3'd4,
    ST_GAME_OVER  = 3'd5
  } game_state_t;

  // Saturating speed step; the compare is done wide so a step larger than
  // the current divisor clamps to the floor instead of wrapping.
  function automatic logic [15:0] ticks_step(input logic [15:0] cur,
                                             input int unsigned step,
                                             input int unsigned floor_v);
    if (32'(cur) >= step + floor_v) return cur - 16'(step);
    return 16'(floor_v);
  endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Signal bundle between the game sequencer and the ball/paddle/display side.
interface pong_game_ctrl_if;
  import pong_pkg::*;

  logic        start;
  logic        pause;
  logic        hit;
  logic        miss_left;
  logic        miss_right;
  logic        game_on;
  logic        serve;
  logic        serve_dir;
  logic [15:0] ticks_per_px;
  score_t      score_left;
  score_t      score_right;
  logic        game_over;
  logic        winner;
  logic [2:0]  state;

  modport slave (
    input  start, pause, hit, miss_left, miss_right,
    output game_on, serve, serve_dir, ticks_per_px, score_left, score_right,
           game_over, winner, state
  );

  modport master (
    output start, pause, hit, miss_left, miss_right,
    input  game_on, serve, serve_dir, ticks_per_px, score_left, score_right,
           game_over, winner, state
  );

endinterface

// File: rtl/pong_game_ctrl_edge_detect.sv
// Rising-edge detector for a level button; the history register resets high
// so a button held through reset does not register a press.
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (!reset) prev_q <= 1'b1;
    else        prev_q <= d_i;
  end

  assign rise_o = d_i & ~prev_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: serve timing, scoring, pause handling and the
// rally speed ramp that drives paddles and ball.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned SERVE_DELAY   = 25_000_000,
  parameter int unsigned WIN_SCORE     = 7,
  parameter int unsigned TICKS_START   = 50,
  parameter int unsigned TICKS_MIN     = 10,
  parameter int unsigned TICKS_STEP    = 5,
  parameter int unsigned HITS_PER_STEP = 4
) (
  input  logic             clk,
  input  logic             reset,
  pong_game_ctrl_if.slave  bus
);

  localparam int unsigned DW = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
  localparam int unsigned HW = (HITS_PER_STEP > 1) ? $clog2(HITS_PER_STEP) : 1;
  localparam logic [DW-1:0] DELAY_LOAD = DW'(SERVE_DELAY - 1);
  localparam score_t        WIN        = score_t'(WIN_SCORE);
  localparam logic [15:0]   TSTART     = 16'(TICKS_START);

  game_state_t   state_q, state_d;
  logic [DW-1:0] delay_q, delay_d;
  logic [HW-1:0] hits_q, hits_d;
  logic [15:0]   ticks_q, ticks_d;
  score_t        score_l_q, score_l_d;
  score_t        score_r_q, score_r_d;
  logic          dir_q, dir_d;
  logic          serve_q, serve_d;
  logic          winner_q, winner_d;

  logic start_rise, pause_rise;

  edge_detect u_start_edge (
    .clk    (clk),
    .reset  (reset),
    .d_i    (bus.start),
    .rise_o (start_rise)
  );

  edge_detect u_pause_edge (
    .clk    (clk),
    .reset  (reset),
    .d_i    (bus.pause),
    .rise_o (pause_rise)
  );

  always_comb begin
    state_d   = state_q;
    delay_d   = delay_q;
    hits_d    = hits_q;
    ticks_d   = ticks_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    dir_d     = dir_q;
    winner_d  = winner_q;
    serve_d   = 1'b0;

    case (state_q)
      ST_IDLE, ST_GAME_OVER: begin
        if (start_rise) begin
          score_l_d = '0;
          score_r_d = '0;
          ticks_d   = TSTART;
          hits_d    = '0;
          dir_d     = 1'b0;
          delay_d   = DELAY_LOAD;
          state_d   = ST_SERVE_WAIT;
        end
      end

      ST_SERVE_WAIT: begin
        if (delay_q == '0) begin
          state_d = ST_PLAY;
          serve_d = 1'b1;
        end else begin
          delay_d = delay_q - DW'(1);
        end
      end

      ST_PLAY: begin
        // A miss outranks a hit or pause in the same cycle; both misses is a let.
        if (bus.miss_left || bus.miss_right) begin
          if (bus.miss_left && !bus.miss_right) begin
            score_r_d = score_r_q + score_t'(1);
            dir_d     = 1'b1;
          end else if (bus.miss_right && !bus.miss_left) begin
            score_l_d = score_l_q + score_t'(1);
            dir_d     = 1'b0;
          end
          state_d = ST_POINT;
        end else begin
          if (bus.hit) begin
            if (32'(hits_q) + 32'd1 >= HITS_PER_STEP) begin
              hits_d  = '0;
              ticks_d = ticks_step(ticks_q, TICKS_STEP, TICKS_MIN);
            end else begin
              hits_d = hits_q + HW'(1);
            end
          end
          if (pause_rise) state_d = ST_PAUSED;
        end
      end

      ST_PAUSED: begin
        if (pause_rise) state_d = ST_PLAY;
      end

      ST_POINT: begin
        if (score_l_q == WIN || score_r_q == WIN) begin
          state_d  = ST_GAME_OVER;
          winner_d = (score_r_q == WIN);
        end else begin
          ticks_d = TSTART;
          hits_d  = '0;
          delay_d = DELAY_LOAD;
          state_d = ST_SERVE_WAIT;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      delay_q   <= '0;
      hits_q    <= '0;
      ticks_q   <= TSTART;
      score_l_q <= '0;
      score_r_q <= '0;
      dir_q     <= 1'b0;
      serve_q   <= 1'b0;
      winner_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      delay_q   <= delay_d;
      hits_q    <= hits_d;
      ticks_q   <= ticks_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      dir_q     <= dir_d;
      serve_q   <= serve_d;
      winner_q  <= winner_d;
    end
  end

  assign bus.game_on      = (state_q == ST_PLAY);
  assign bus.game_over    = (state_q == ST_GAME_OVER);
  assign bus.serve        = serve_q;
  assign bus.serve_dir    = dir_q;
  assign bus.ticks_per_px = ticks_q;
  assign bus.score_left   = score_l_q;
  assign bus.score_right  = score_r_q;
  assign bus.winner       = winner_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: two instances differing only in speed step share
// one stimulus stream and are checked against a rule-level match model.
module tb_pong_game_ctrl;

  localparam int SD     = 4;
  localparam int WIN    = 3;
  localparam int HPS    = 2;
  localparam int TS     = 50;
  localparam int TMIN   = 10;
  localparam int STEP_A = 5;
  localparam int STEP_B = 30;

  localparam int P_IDLE = 0, P_WAIT = 1, P_PLAY = 2, P_PAUSED = 3, P_POINT = 4, P_OVER = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic pause = 1'b0;
  logic hit = 1'b0;
  logic ml = 1'b0;
  logic mr = 1'b0;

  always #5 clk = ~clk;

  pong_game_ctrl_if ifa ();
  pong_game_ctrl_if ifb ();

  assign ifa.start = start;
  assign ifa.pause = pause;
  assign ifa.hit = hit;
  assign ifa.miss_left = ml;
  assign ifa.miss_right = mr;
  assign ifb.start = start;
  assign ifb.pause = pause;
  assign ifb.hit = hit;
  assign ifb.miss_left = ml;
  assign ifb.miss_right = mr;

  pong_game_ctrl #(.SERVE_DELAY(SD), .WIN_SCORE(WIN), .TICKS_STEP(STEP_A), .HITS_PER_STEP(HPS))
    dut_a (.clk(clk), .reset(reset), .bus(ifa));

  pong_game_ctrl #(.SERVE_DELAY(SD), .WIN_SCORE(WIN), .TICKS_STEP(STEP_B), .HITS_PER_STEP(HPS))
    dut_b (.clk(clk), .reset(reset), .bus(ifb));

  int total = 0;
  int bad = 0;

  // Match model: rally hits since the last serve determine the speed directly.
  int m_phase, m_sl, m_sr, m_dir, m_rally, m_wait, m_winner;
  bit m_serve, m_ps, m_pp;

  function automatic int exp_ticks(int step);
    int t;
    t = TS - step * (m_rally / HPS);
    return (t < TMIN) ? TMIN : t;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = P_IDLE; m_sl = 0; m_sr = 0; m_dir = 0; m_rally = 0;
    m_wait = 0; m_winner = 0; m_serve = 0; m_ps = 1; m_pp = 1;
  endtask

  task automatic model_step();
    bit se, pe;
    if (!reset) begin
      model_reset();
      return;
    end
    se = start && !m_ps;
    pe = pause && !m_pp;
    m_ps = start;
    m_pp = pause;
    m_serve = 0;
    case (m_phase)
      P_IDLE, P_OVER: if (se) begin
        m_sl = 0; m_sr = 0; m_rally = 0; m_dir = 0; m_wait = 0; m_phase = P_WAIT;
      end
      P_WAIT: begin
        m_wait++;
        if (m_wait == SD) begin m_phase = P_PLAY; m_serve = 1; end
      end
      P_PLAY: begin
        if (ml || mr) begin
          if (ml && !mr) begin m_sr++; m_dir = 1; end
          if (mr && !ml) begin m_sl++; m_dir = 0; end
          m_phase = P_POINT;
        end else begin
          if (hit) m_rally++;
          if (pe) m_phase = P_PAUSED;
        end
      end
      P_PAUSED: if (pe) m_phase = P_PLAY;
      P_POINT: begin
        if (m_sl == WIN || m_sr == WIN) begin
          m_phase = P_OVER;
          m_winner = (m_sr == WIN) ? 1 : 0;
        end else begin
          m_rally = 0; m_wait = 0; m_phase = P_WAIT;
        end
      end
      default: ;
    endcase
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("game_on", 32'(ifa.game_on), 32'(m_phase == P_PLAY));
    chk("game_over", 32'(ifa.game_over), 32'(m_phase == P_OVER));
    chk("serve", 32'(ifa.serve), 32'(m_serve));
    chk("serve_dir", 32'(ifa.serve_dir), 32'(m_dir));
    chk("score_left", 32'(ifa.score_left), 32'(m_sl));
    chk("score_right", 32'(ifa.score_right), 32'(m_sr));
    chk("ticks_a", 32'(ifa.ticks_per_px), 32'(exp_ticks(STEP_A)));
    chk("ticks_b", 32'(ifb.ticks_per_px), 32'(exp_ticks(STEP_B)));
    chk("serve_b", 32'(ifb.serve), 32'(m_serve));
    if (m_phase == P_OVER) chk("winner", 32'(ifa.winner), 32'(m_winner));
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic pulse(input logic h, input logic l, input logic r);
    hit = h; ml = l; mr = r;
    cyc();
    hit = 1'b0; ml = 1'b0; mr = 1'b0;
  endtask

  initial begin
    model_reset();

    // Reset with start held: reset values, then no phantom start edge.
    reset = 1'b0; start = 1'b1;
    idle(2);
    chk("rst_ticks", 32'(ifa.ticks_per_px), 32'd50);
    chk("rst_winner", 32'(ifa.winner), 32'd0);
    reset = 1'b1;
    idle(2);
    chk("no_edge_after_rst", 32'(ifa.game_on | ifa.game_over), 32'd0);

    // Start a match and reach the first serve.
    start = 1'b0; cyc();
    start = 1'b1; cyc();
    start = 1'b0;
    idle(5);
    chk("first_play", 32'(ifa.game_on), 32'd1);

    // Six hits ramp the speed.
    for (int i = 0; i < 6; i++) begin
      pulse(1'b1, 1'b0, 1'b0);
      cyc();
    end
    chk("ticks_a_ramp", 32'(ifa.ticks_per_px), 32'd35);
    chk("ticks_b_floor", 32'(ifb.ticks_per_px), 32'd10);

    // Right player misses, then a let.
    pulse(1'b0, 1'b0, 1'b1);
    chk("miss_r_score", 32'(ifa.score_left), 32'd1);
    idle(6);
    chk("ticks_reload", 32'(ifa.ticks_per_px), 32'd50);
    pulse(1'b0, 1'b1, 1'b1);
    chk("let_scores", 32'({ifa.score_left, ifa.score_right}), 32'h10);
    idle(6);

    // Pause: events ignored, resume without serve.
    pause = 1'b1; cyc();
    chk("paused", 32'(ifa.game_on), 32'd0);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    pause = 1'b0; cyc();
    pause = 1'b1; cyc();
    chk("resumed", 32'(ifa.game_on), 32'd1);
    pause = 1'b0;
    idle(2);

    // Three left misses end the match for the right player.
    repeat (3) begin
      pulse(1'b0, 1'b1, 1'b0);
      idle(6);
    end
    chk("over", 32'(ifa.game_over), 32'd1);
    chk("over_winner", 32'(ifa.winner), 32'd1);
    chk("over_score_r", 32'(ifa.score_right), 32'd3);

    // Restart, then reset mid-play with start held high.
    start = 1'b1; cyc();
    chk("restart_scores", 32'({ifa.score_left, ifa.score_right}), 32'h00);
    start = 1'b0;
    idle(6);
    start = 1'b1; cyc();
    reset = 1'b0; cyc();
    chk("midplay_rst_on", 32'(ifa.game_on), 32'd0);
    reset = 1'b1;
    idle(3);
    chk("midplay_no_edge", 32'(ifa.game_on | ifa.game_over), 32'd0);
    start = 1'b0;

    // Randomised play against the model.
    for (int i = 0; i < 3000; i++) begin
      hit = ($urandom_range(0, 99) < 25);
      ml = ($urandom_range(0, 99) < 4);
      mr = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 99) < 6) start = ~start;
      if ($urandom_range(0, 99) < 5) pause = ~pause;
      reset = ($urandom_range(0, 299) != 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Top-level game sequencer for the Pong design. It owns the match state machine, and gates both `Paddle` instances and the ball engine through `game_on`. It issues serve pulses after a fixed delay, keeps both scores, and ramps `ticks_per_px` down as a rally lengthens. Ball logic reports hits and misses to it; it drives the paddles and the score display.

## Interface
- `SERVE_DELAY`, 25_000_000: cycles of idle play-field before each serve.
- `WIN_SCORE`, 7: points needed to win; must be ≤15.
- `TICKS_START`, 50: `ticks_per_px` at each serve.
- `TICKS_MIN`, 10: floor for `ticks_per_px`.
- `TICKS_STEP`, 5: decrement applied per speed step.
- `HITS_PER_STEP`, 4: paddle hits per speed step.

- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-low reset.
- `start` in 1: start button, level; acted on at its rising edge.
- `pause` in 1: pause button, level; acted on at its rising edge.
- `hit` in 1: one-cycle pulse when the ball strikes either paddle.
- `miss_left` in 1: one-cycle pulse when the ball passes the left paddle.
- `miss_right` in 1: one-cycle pulse when the ball passes the right paddle.
- `game_on` out 1: paddles and ball may move.
- `serve` out 1: one-cycle pulse that launches the ball.
- `serve_dir` out 1: serve direction; 0 = toward right, 1 = toward left.
- `ticks_per_px` out 16: speed divisor fed to the paddles and the ball.
- `score_left` out 4: left player's score.
- `score_right` out 4: right player's score.
- `game_over` out 1: match finished.
- `winner` out 1: winning side; 0 = left, 1 = right; valid while `game_over` is high.
- `state` out 3: current FSM state, for debug and display.

## Operation
- Edge detect: `start` and `pause` are each delayed one register. The previous-value register resets to 1, so a button held through reset produces no edge.
- States: IDLE, SERVE_WAIT, PLAY, PAUSED, POINT, GAME_OVER.
- IDLE
  - Start edge: clear both scores, set `ticks_per_px`=TICKS_START, clear hit count, set `serve_dir`=0, load the delay counter, go to SERVE_WAIT.
- SERVE_WAIT
  - Delay counter decrements each cycle.
  - When it reaches 0, go to PLAY and assert `serve` for exactly that first PLAY cycle.
- PLAY
  - `hit` increments the hit counter.
  - When the hit counter reaches HITS_PER_STEP, clear it and set `ticks_per_px` = max(`ticks_per_px` − TICKS_STEP, TICKS_MIN).
  - The subtraction must not underflow when TICKS_STEP is larger than the current value.
  - `miss_left` adds 1 to `score_right` and sets `serve_dir`=1.
  - `miss_right` adds 1 to `score_left` and sets `serve_dir`=0.
  - Either miss moves the FSM to POINT.
  - Pause edge goes to PAUSED.
- PAUSED
  - `hit` and misses are ignored.
  - Pause edge returns to PLAY with no serve pulse; speed and hit count are preserved.
- POINT (one cycle)
  - If either score equals WIN_SCORE: go to GAME_OVER and latch `winner`.
  - Otherwise: set `ticks_per_px`=TICKS_START, clear hit count, load the delay counter, go to SERVE_WAIT.
- GAME_OVER
  - Scores are held.
  - Start edge behaves exactly as the start edge in IDLE.
- Simultaneous events
  - `miss_left` and `miss_right` in the same cycle is a let: no score change, `serve_dir` unchanged, go to POINT.
  - A miss beats `hit` and a pause edge in the same cycle.
  - Start edge is ignored outside IDLE and GAME_OVER.
- Reset, including mid-match: on the next `clk` edge with `reset`=0 the FSM is IDLE and every output takes its reset value. Reset values:
  - `game_on`=0, `serve`=0, `serve_dir`=0
  - `ticks_per_px`=TICKS_START
  - both scores 0
  - `game_over`=0, `winner`=0

## Timing
- All state and outputs are registered at the rising edge of `clk`.
- `game_on` is 1 exactly when state is PLAY; `game_over` is 1 exactly when state is GAME_OVER.
- Start edge sampled at edge N: SERVE_WAIT from N+1; PLAY and the `serve` pulse at N+1+SERVE_DELAY.
- A miss at edge M:
  - score updates and POINT at M+1;
  - SERVE_WAIT at M+2;
  - next serve at M+2+SERVE_DELAY.
- A speed step takes effect the cycle after the qualifying `hit`.

## Structure
- `pong_pkg` holds:
  - `game_state_t` enum (3-bit) for the FSM states;
  - constants X_RES=800 and Y_RES=600;
  - `score_t` (logic [3:0]).
- Sub-module `edge_detect` (rising edge, reset value 1) is instantiated twice, once for `start` and once for `pause`.
- Scores, hit counter, delay counter and speed register live in `pong_game_ctrl`.

## Test plan
Override SERVE_DELAY=4, WIN_SCORE=3, HITS_PER_STEP=2.
- Start after reset -> SERVE_WAIT for 4 cycles, then `serve`=1 for one cycle and `game_on`=1; `ticks_per_px`=50.
- 6 `hit` pulses in PLAY -> `ticks_per_px` goes 45, 40, 35. With TICKS_STEP=30 and 2 hits -> 20, then held at the 10 floor.
- `miss_right` -> `score_left`=1, `serve_dir`=0, `ticks_per_px` back to 50, `serve` 6 cycles after the miss. `miss_left`+`miss_right` together -> scores unchanged.
- Pause edge in PLAY -> `game_on`=0 and `hit`/miss ignored; second pause edge -> `game_on`=1 with no `serve` pulse.
- Three `miss_left` -> `score_right`=3, `game_over`=1, `winner`=1. Start edge -> scores 0, new serve.
- `reset`=0 mid-PLAY with `start` held high -> all outputs at reset values, and no start edge after `reset`=1.
